// File: rtl/dma_sequencer.sv
// Multi-cycle DMA sequencer between the core's execute stage, the data-memory
// port and the CGRA buffer/control port: word copies (STC/LFC) and CGRA kicks (SCA).
module dma_sequencer #(
  parameter int unsigned DW      = 32,
  parameter int unsigned CGRA_AW = 6,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         dma_ctrl_i,
  input  logic [31:0]        mem_base_i,
  input  logic [CGRA_AW-1:0] cgra_base_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic [DW-1:0]      mem_rdata_i,
  output logic               cgra_we_o,
  output logic               cgra_re_o,
  output logic [CGRA_AW-1:0] cgra_addr_o,
  output logic [DW-1:0]      cgra_wdata_o,
  input  logic [DW-1:0]      cgra_rdata_i,
  output logic               cgra_start_o,
  input  logic               cgra_done_i
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_STC  = 2'b01;
  localparam logic [1:0] OP_SCA  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_KICK, S_WAIT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        mem_base_q, mem_base_d;
  logic [CGRA_AW-1:0] cgra_base_q, cgra_base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   k_nx;

  logic               busy_q, busy_d, done_q, done_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               cgra_we_q, cgra_we_d, cgra_re_q, cgra_re_d;
  logic [CGRA_AW-1:0] cgra_addr_q, cgra_addr_d;
  logic               cgra_start_q, cgra_start_d;

  assign k_nx = k_q + LEN_W'(1);

  // Next state plus the strobes of the state being entered, so every strobe is a flop.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mem_base_d   = mem_base_q;
    cgra_base_d  = cgra_base_q;
    len_d        = len_q;
    k_d          = k_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    cgra_we_d    = 1'b0;
    cgra_re_d    = 1'b0;
    cgra_addr_d  = '0;
    cgra_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && (dma_ctrl_i != OP_NONE)) begin
          op_d        = dma_ctrl_i;
          mem_base_d  = mem_base_i;
          cgra_base_d = cgra_base_i;
          len_d       = len_i;
          k_d         = '0;
          busy_d      = 1'b1;
          if (dma_ctrl_i == OP_SCA) begin
            state_d      = S_KICK;
            cgra_start_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            if (dma_ctrl_i == OP_STC) begin
              mem_req_d  = 1'b1;
              mem_addr_d = mem_base_i;
            end else begin
              cgra_re_d   = 1'b1;
              cgra_addr_d = cgra_base_i;
            end
          end
        end
      end
      S_RD: begin
        state_d = S_WR;
        busy_d  = 1'b1;
        if (op_q == OP_STC) begin
          cgra_we_d   = 1'b1;
          cgra_addr_d = cgra_base_q + CGRA_AW'(k_q);
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = mem_base_q + (32'(k_q) << 2);
        end
      end
      S_WR: begin
        busy_d = 1'b1;
        k_d    = k_nx;
        if (k_nx == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          if (op_q == OP_STC) begin
            mem_req_d  = 1'b1;
            mem_addr_d = mem_base_q + (32'(k_nx) << 2);
          end else begin
            cgra_re_d   = 1'b1;
            cgra_addr_d = cgra_base_q + CGRA_AW'(k_nx);
          end
        end
      end
      S_KICK: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (cgra_done_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      mem_base_q   <= '0;
      cgra_base_q  <= '0;
      len_q        <= '0;
      k_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      cgra_we_q    <= 1'b0;
      cgra_re_q    <= 1'b0;
      cgra_addr_q  <= '0;
      cgra_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mem_base_q   <= mem_base_d;
      cgra_base_q  <= cgra_base_d;
      len_q        <= len_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      cgra_we_q    <= cgra_we_d;
      cgra_re_q    <= cgra_re_d;
      cgra_addr_q  <= cgra_addr_d;
      cgra_start_q <= cgra_start_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign cgra_we_o    = cgra_we_q;
  assign cgra_re_o    = cgra_re_q;
  assign cgra_addr_o  = cgra_addr_q;
  assign cgra_start_o = cgra_start_q;

  // Read data arrives in the write cycle itself, so the write data is a gated pass-through.
  assign cgra_wdata_o = cgra_we_q ? mem_rdata_i  : '0;
  assign mem_wdata_o  = mem_we_q  ? cgra_rdata_i : '0;

endmodule

// File: tb/tb_dma_sequencer.sv
// Randomized bench for dma_sequencer against a cycle-schedule reference model.
module tb_dma_sequencer;

  localparam int unsigned DW      = 32;
  localparam int unsigned CGRA_AW = 6;
  localparam int unsigned LEN_W   = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [1:0]         dma_ctrl_i;
  logic [31:0]        mem_base_i;
  logic [CGRA_AW-1:0] cgra_base_i;
  logic [LEN_W-1:0]   len_i;
  logic               busy_o, done_o, mem_req_o, mem_we_o;
  logic [31:0]        mem_addr_o;
  logic [DW-1:0]      mem_wdata_o;
  logic [DW-1:0]      mem_rdata_i = '0;
  logic               cgra_we_o, cgra_re_o;
  logic [CGRA_AW-1:0] cgra_addr_o;
  logic [DW-1:0]      cgra_wdata_o;
  logic [DW-1:0]      cgra_rdata_i = '0;
  logic               cgra_start_o;
  logic               cgra_done_i;

  int total = 0;
  int bad   = 0;

  dma_sequencer #(.DW(DW), .CGRA_AW(CGRA_AW), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .dma_ctrl_i(dma_ctrl_i),
    .mem_base_i(mem_base_i), .cgra_base_i(cgra_base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .cgra_we_o(cgra_we_o), .cgra_re_o(cgra_re_o), .cgra_addr_o(cgra_addr_o),
    .cgra_wdata_o(cgra_wdata_o), .cgra_rdata_i(cgra_rdata_i),
    .cgra_start_o(cgra_start_o), .cgra_done_i(cgra_done_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] cgra_val(input logic [5:0] a);
    return (32'(a) * 32'h01000193) + 32'h12345678;
  endfunction

  // Memory and CGRA buffer models: data for a read appears in the following cycle.
  always @(posedge clk_i) begin
    mem_rdata_i  <= (mem_req_o && !mem_we_o) ? mem_val(mem_addr_o) : $urandom;
    cgra_rdata_i <= cgra_re_o ? cgra_val(cgra_addr_o) : $urandom;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] raw_outs();
    return 128'({busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                 cgra_we_o, cgra_re_o, cgra_addr_o, cgra_wdata_o, cgra_start_o});
  endfunction

  // Bus activity with addresses/data only meaningful while their strobe is up.
  function automatic logic [127:0] obs_bus();
    logic [31:0] ma, mwd, cwd;
    logic [5:0]  ca;
    ma  = mem_req_o ? mem_addr_o : 32'h0;
    mwd = mem_we_o ? mem_wdata_o : 32'h0;
    ca  = (cgra_we_o || cgra_re_o) ? cgra_addr_o : 6'h0;
    cwd = cgra_we_o ? cgra_wdata_o : 32'h0;
    return 128'({mem_req_o, mem_we_o, ma, mwd, cgra_we_o, cgra_re_o, ca, cwd});
  endfunction

  // Word k is read in cycle 2k+1 and written in cycle 2k+2.
  function automatic logic [127:0] exp_bus(input logic [1:0] op, input logic [31:0] mb,
                                           input logic [5:0] cb, input int n, input int c);
    logic        mreq, mwe, cwe, cre;
    logic [31:0] ma, mwd, cwd, mem_a;
    logic [5:0]  ca, cgra_a;
    int          k;
    {mreq, mwe, cwe, cre} = 4'b0;
    ma = 0; mwd = 0; cwd = 0; ca = 0;
    if (op != 2'b11 && c >= 1 && c <= 2 * n) begin
      k      = (c - 1) / 2;
      mem_a  = mb + 32'(4 * k);
      cgra_a = 6'((int'(cb) + k) % 64);
      if (c % 2 == 1) begin
        if (op == 2'b01) begin mreq = 1; ma = mem_a; end
        else begin cre = 1; ca = cgra_a; end
      end else begin
        if (op == 2'b01) begin cwe = 1; ca = cgra_a; cwd = mem_val(mem_a); end
        else begin mreq = 1; mwe = 1; ma = mem_a; mwd = cgra_val(cgra_a); end
      end
    end
    return 128'({mreq, mwe, ma, mwd, cwe, cre, ca, cwd});
  endfunction

  // Run one operation; d = cycles the CGRA spends in WAIT before raising done (SCA only).
  task automatic run_op(input logic [1:0] op, input logic [31:0] mb, input logic [5:0] cb,
                        input int n, input int d);
    int ed;
    @(negedge clk_i);
    start_i = 1; dma_ctrl_i = op; mem_base_i = mb; cgra_base_i = cb; len_i = 8'(n);
    cgra_done_i = 0;
    if (op == 2'b11) ed = 3 + d;
    else ed = (n == 0) ? 1 : 2 * n + 1;
    for (int c = 1; c <= ed + 1; c++) begin
      @(negedge clk_i);
      chk("ctl", 128'({busy_o, done_o, cgra_start_o}),
          128'({c <= ed, c == ed, (op == 2'b11) && (c == 1)}));
      chk("bus", obs_bus(), exp_bus(op, mb, cb, n, c));
      if (c < ed) begin
        start_i = 1'($urandom); dma_ctrl_i = 2'($urandom); mem_base_i = $urandom;
        cgra_base_i = 6'($urandom); len_i = 8'($urandom);
      end else start_i = 0;
      if (op != 2'b11) cgra_done_i = 1'($urandom);
      else if (c == 1) cgra_done_i = 1'($urandom);
      else cgra_done_i = (c >= 2 + d) && (c < ed);
    end
    cgra_done_i = 0;
  endtask

  initial begin
    rst_ni = 0; start_i = 0; dma_ctrl_i = 0; mem_base_i = 0; cgra_base_i = 0; len_i = 0;
    cgra_done_i = 0;
    @(posedge clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("reset", raw_outs(), 128'h0);
      start_i = 1'($urandom); dma_ctrl_i = 2'($urandom); mem_base_i = $urandom;
      cgra_base_i = 6'($urandom); len_i = 8'($urandom); cgra_done_i = 1'($urandom);
    end
    @(negedge clk_i);
    chk("reset", raw_outs(), 128'h0);
    rst_ni = 1; start_i = 0; cgra_done_i = 0;

    run_op(2'b01, 32'h100, 6'd2, 3, 0);
    run_op(2'b10, 32'hFFFFFFFC, 6'd63, 2, 0);
    run_op(2'b11, 32'h0, 6'd0, 0, 9);
    run_op(2'b11, 32'h0, 6'd0, 0, 0);
    run_op(2'b01, 32'h40, 6'd5, 0, 0);
    run_op(2'b10, 32'h2000, 6'd7, 0, 0);
    run_op(2'b01, 32'hFFFFFF00, 6'd60, 255, 0);

    // A start with code 00 must leave the sequencer idle.
    @(negedge clk_i);
    start_i = 1; dma_ctrl_i = 2'b00; mem_base_i = $urandom; len_i = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      start_i = (i == 0);
      chk("nop", raw_outs(), 128'h0);
    end
    start_i = 0;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      run_op(op, $urandom, 6'($urandom), $urandom_range(0, 12), $urandom_range(0, 6));
    end

    // Reset in the middle of a transfer aborts all bus activity.
    @(negedge clk_i);
    start_i = 1; dma_ctrl_i = 2'b01; mem_base_i = 32'h800; cgra_base_i = 6'd1; len_i = 8'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      start_i = 0;
    end
    rst_ni = 0;
    @(negedge clk_i);
    chk("midrst", raw_outs(), 128'h0);
    rst_ni = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("postrst", raw_outs(), 128'h0);
    end
    run_op(2'b10, 32'h300, 6'd9, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_sequencer.md
# dma_sequencer

Multi-cycle transfer sequencer driven by the 2-bit DMA control code from the core's custom-instruction decode: 01 = STC (store data memory into CGRA buffer), 10 = LFC (load CGRA buffer back to data memory), 11 = SCA (start CGRA array and wait for completion). It sits between the core's execute stage, the data-memory port and the CGRA buffer/control port. It stalls the core via `busy_o` until the operation finishes.

## Interface
Parameters:
- `DW`, 32, data word width (data memory and CGRA buffer)
- `CGRA_AW`, 6, CGRA buffer word-address width
- `LEN_W`, 8, transfer-length width (in words)

Ports:
- `clk_i`  input  1  clock, all logic on rising edge
- `rst_ni`  input  1  reset, synchronous, active-low
- `start_i`  input  1  command valid from execute stage
- `dma_ctrl_i`  input  2  operation code (00 none, 01 STC, 10 LFC, 11 SCA)
- `mem_base_i`  input  32  data-memory byte base address
- `cgra_base_i`  input  CGRA_AW  CGRA buffer word base address
- `len_i`  input  LEN_W  number of words to move (STC/LFC only)
- `busy_o`  output  1  operation in progress, core stall
- `done_o`  output  1  one-cycle completion pulse
- `mem_req_o`, `mem_we_o`  output  1  data-memory request / write enable
- `mem_addr_o`  output  32  data-memory byte address
- `mem_wdata_o`  output  DW  data-memory write data
- `mem_rdata_i`  input  DW  data-memory read data, valid cycle after a read request
- `cgra_we_o`, `cgra_re_o`  output  1  CGRA buffer write / read enable
- `cgra_addr_o`  output  CGRA_AW  CGRA buffer word address
- `cgra_wdata_o`  output  DW  CGRA buffer write data
- `cgra_rdata_i`  input  DW  CGRA buffer read data, valid cycle after `cgra_re_o`
- `cgra_start_o`  output  1  one-cycle CGRA kick pulse
- `cgra_done_i`  input  1  CGRA completion (level or pulse)

## Operation
- States: IDLE, RD, WR, KICK, WAIT, DONE.
- IDLE: on `start_i` with `dma_ctrl_i`≠00, latch code, `mem_base_i`, `cgra_base_i`, `len_i`; counter k=0. STC/LFC with len>0 → RD; len=0 → DONE; SCA → KICK. `start_i` with code 00 ignored.
- RD: STC issues memory read at mem_base+4k (`mem_req_o`=1, `mem_we_o`=0); LFC asserts `cgra_re_o` at cgra_base+k. → WR.
- WR: STC writes `mem_rdata_i` to CGRA cgra_base+k (`cgra_we_o`=1); LFC writes `cgra_rdata_i` to memory mem_base+4k (`mem_req_o`=`mem_we_o`=1). k+1; if k+1==len → DONE else → RD.
- KICK: `cgra_start_o`=1 for this cycle only → WAIT.
- WAIT: hold until `cgra_done_i`=1 → DONE. No timeout.
- DONE: `done_o`=1 one cycle → IDLE.
- Address arithmetic: memory address mod 2^32 (wraps), CGRA address mod 2^CGRA_AW (wraps); k is LEN_W bits, max len 2^LEN_W−1.
- `start_i` outside IDLE ignored; latched operands do not change mid-operation.

## Timing
- Reset (`rst_ni`=0 at edge): state IDLE, all outputs 0 (busy, done, req, we, re, start, addresses, wdata), k=0. Reset mid-transfer aborts immediately; no further bus activity.
- Accept at edge 0; `busy_o`=1 from cycle 1 through DONE cycle inclusive, 0 in IDLE. Strobes are registered-state decoded, not combinational on `start_i`.
- STC/LFC len=N: 2 cycles/word; RD at cycle 2k+1, WR at 2k+2, DONE at 2N+1, IDLE at 2N+2.
- len=0: DONE at cycle 1, no bus strobes.
- SCA: KICK cycle 1, WAIT from cycle 2; `cgra_done_i` sampled high in cycle t → DONE at t+1. `cgra_done_i` high during KICK ignored.
- Read-data contract: 1-cycle latency fixed; no wait states supported.

## Test plan
- Reset: hold `rst_ni`=0 3 cycles with random inputs → all outputs 0, busy 0.
- STC mem_base=0x100, cgra_base=2, len=3, memory returns 0xA,0xB,0xC → CGRA writes (2,0xA),(3,0xB),(4,0xC); read addrs 0x100,0x104,0x108; `done_o` at cycle 7.
- LFC cgra_base=63 (CGRA_AW=6), len=2, mem_base=0xFFFFFFFC → CGRA reads 63 then 0 (wrap), memory writes 0xFFFFFFFC then 0x00000000; done at cycle 5.
- SCA with `cgra_done_i` raised 10 cycles after kick → `cgra_start_o` single pulse cycle 1, busy held, `done_o` exactly one cycle after done sampled.
- len=0 STC and code-00 start → first: done at cycle 1 with no strobes; second: busy stays 0.
- `start_i` pulsed mid-STC with new operands, and `rst_ni` low mid-transfer → operands unchanged / sequencer returns to IDLE with outputs 0 next cycle.
